// File: rtl/conv_stream_engine_if.sv
// Control, sample-stream and OFM read-port bundle for conv_stream_engine.
// The master side (controller/testbench) drives runs; the slave side is the engine.
interface conv_stream_engine_if #(
    parameter int CONV_NUM = 4,
    parameter int DATA_W   = 8,
    parameter int K        = 4,
    parameter int ADDR_W   = 8
);
    localparam int CH_W  = (CONV_NUM > 1) ? $clog2(CONV_NUM) : 1;
    localparam int TAP_W = (K > 1) ? $clog2(K) : 1;

    logic                         start;
    logic [15:0]                  len;
    logic                         stride2;
    logic                         relu_en;
    logic                         flt_we;
    logic [CH_W-1:0]              flt_ch;
    logic [TAP_W-1:0]             flt_tap;
    logic signed [DATA_W-1:0]     flt_data;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_W-1:0]     in_data;
    logic                         busy;
    logic                         done;
    logic [ADDR_W:0]              ofm_count;
    logic [CONV_NUM*ADDR_W-1:0]   ofm_addr;
    logic [CONV_NUM*DATA_W-1:0]   ofm_out;

    modport master (
        output start, len, stride2, relu_en, flt_we, flt_ch, flt_tap, flt_data,
               in_valid, in_data, ofm_addr,
        input  in_ready, busy, done, ofm_count, ofm_out
    );

    modport slave (
        input  start, len, stride2, relu_en, flt_we, flt_ch, flt_tap, flt_data,
               in_valid, in_data, ofm_addr,
        output in_ready, busy, done, ofm_count, ofm_out
    );
endinterface

// File: rtl/conv_stream_engine.sv
// Multi-channel 1-D convolution over a sample stream: K-tap window, one MAC per cycle
// per channel, shift/relu/saturate, results into per-channel OFM buffers with registered reads.
module conv_stream_engine #(
    parameter int CONV_NUM = 4,
    parameter int DATA_W   = 8,
    parameter int K        = 4,
    parameter int ADDR_W   = 8,
    parameter int SHIFT    = 0
) (
    input logic                 clk,
    input logic                 rst,
    conv_stream_engine_if.slave bus_io
);
    localparam int TAP_W = (K > 1) ? $clog2(K) : 1;
    localparam int ACC_W = 2 * DATA_W + $clog2(K);
    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [15:0]             K_LEN    = 16'(K);
    localparam logic [TAP_W-1:0]        LAST_TAP = TAP_W'(K - 1);
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, FILL, MAC, WRITE, DONE} state_t;

    state_t                    state_q, state_d;
    logic [15:0]               len_q, len_d;
    logic                      stride2_q, stride2_d;
    logic                      relu_q, relu_d;
    logic [15:0]               sampleCnt_q, sampleCnt_d;
    logic [TAP_W-1:0]          macCnt_q, macCnt_d;
    logic [CNT_W-1:0]          ofmCount_q, ofmCount_d;

    logic signed [DATA_W-1:0]  weight_q [CONV_NUM][K];
    logic signed [DATA_W-1:0]  window_q [K];
    logic signed [ACC_W-1:0]   acc_q    [CONV_NUM];
    logic signed [DATA_W-1:0]  ofmMem   [CONV_NUM][DEPTH];
    logic signed [DATA_W-1:0]  ofmOut_q [CONV_NUM];

    logic signed [2*DATA_W-1:0] product [CONV_NUM];
    logic signed [ACC_W-1:0]    shifted [CONV_NUM];
    logic signed [DATA_W-1:0]   result  [CONV_NUM];

    logic        accept;
    logic [15:0] mNext;
    logic        windowHit;

    assign accept    = (state_q == FILL) && bus_io.in_valid;
    assign mNext     = sampleCnt_q + 16'd1;
    // With stride 2 only every other full window fires: (m-K) even means m and K share parity.
    assign windowHit = (mNext >= K_LEN) && (!stride2_q || (mNext[0] == K_LEN[0]));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        stride2_d   = stride2_q;
        relu_d      = relu_q;
        sampleCnt_d = sampleCnt_q;
        macCnt_d    = macCnt_q;
        ofmCount_d  = ofmCount_q;
        case (state_q)
            IDLE: begin
                if (bus_io.start) begin
                    len_d       = bus_io.len;
                    stride2_d   = bus_io.stride2;
                    relu_d      = bus_io.relu_en;
                    sampleCnt_d = '0;
                    ofmCount_d  = '0;
                    state_d     = (bus_io.len == 16'd0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    sampleCnt_d = mNext;
                    macCnt_d    = '0;
                    if (windowHit) begin
                        state_d = MAC;
                    end else if (mNext == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            MAC: begin
                macCnt_d = macCnt_q + TAP_W'(1);
                if (macCnt_q == LAST_TAP) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!ofmCount_q[ADDR_W]) begin
                    ofmCount_d = ofmCount_q + CNT_W'(1);
                end
                state_d = (sampleCnt_q == len_q) ? DONE : FILL;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            stride2_q   <= 1'b0;
            relu_q      <= 1'b0;
            sampleCnt_q <= '0;
            macCnt_q    <= '0;
            ofmCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            stride2_q   <= stride2_d;
            relu_q      <= relu_d;
            sampleCnt_q <= sampleCnt_d;
            macCnt_q    <= macCnt_d;
            ofmCount_q  <= ofmCount_d;
        end
    end

    always_comb begin
        for (int c = 0; c < CONV_NUM; c++) begin
            product[c] = weight_q[c][macCnt_q] * window_q[macCnt_q];
            shifted[c] = acc_q[c] >>> SHIFT;
            if (relu_q && shifted[c] < 0) begin
                shifted[c] = '0;
            end
            if (shifted[c] > ACC_W'(OUT_MAX)) begin
                result[c] = OUT_MAX;
            end else if (shifted[c] < ACC_W'(OUT_MIN)) begin
                result[c] = OUT_MIN;
            end else begin
                result[c] = shifted[c][DATA_W-1:0];
            end
        end
    end

    // Accumulators are cleared while filling so each MAC span starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CONV_NUM; c++) begin
                acc_q[c] <= '0;
                for (int t = 0; t < K; t++) begin
                    weight_q[c][t] <= '0;
                end
            end
            for (int i = 0; i < K; i++) begin
                window_q[i] <= '0;
            end
        end else begin
            if (state_q == IDLE && bus_io.flt_we) begin
                weight_q[bus_io.flt_ch][bus_io.flt_tap] <= bus_io.flt_data;
            end
            if (accept) begin
                for (int i = 0; i < K - 1; i++) begin
                    window_q[i] <= window_q[i+1];
                end
                window_q[K-1] <= bus_io.in_data;
            end
            for (int c = 0; c < CONV_NUM; c++) begin
                if (state_q == FILL) begin
                    acc_q[c] <= '0;
                end else if (state_q == MAC) begin
                    acc_q[c] <= acc_q[c] + ACC_W'(product[c]);
                end
            end
        end
    end

    // Buffer contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (state_q == WRITE && !ofmCount_q[ADDR_W]) begin
            for (int c = 0; c < CONV_NUM; c++) begin
                ofmMem[c][ofmCount_q[ADDR_W-1:0]] <= result[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CONV_NUM; c++) begin
                ofmOut_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CONV_NUM; c++) begin
                ofmOut_q[c] <= ofmMem[c][bus_io.ofm_addr[c*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign bus_io.in_ready  = (state_q == FILL);
    assign bus_io.busy      = (state_q != IDLE);
    assign bus_io.done      = (state_q == DONE);
    assign bus_io.ofm_count = ofmCount_q;

    always_comb begin
        bus_io.ofm_out = '0;
        for (int c = 0; c < CONV_NUM; c++) begin
            bus_io.ofm_out[c*DATA_W +: DATA_W] = ofmOut_q[c];
        end
    end
endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench for conv_stream_engine: directed and randomized runs compared
// against a direct convolution model computed from the sample/weight arrays.
module tb_conv_stream_engine;
    localparam int CONV_NUM = 4;
    localparam int DATA_W   = 8;
    localparam int K        = 4;
    localparam int ADDR_W   = 8;
    localparam int SHIFT    = 0;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int CH_W     = $clog2(CONV_NUM);
    localparam int TAP_W    = $clog2(K);
    localparam int OUT_MAX  = (1 << (DATA_W - 1)) - 1;
    localparam int OUT_MIN  = -(1 << (DATA_W - 1));

    logic clk = 1'b0;
    logic rst;

    conv_stream_engine_if #(.CONV_NUM(CONV_NUM), .DATA_W(DATA_W), .K(K), .ADDR_W(ADDR_W)) bus ();

    conv_stream_engine #(
        .CONV_NUM(CONV_NUM), .DATA_W(DATA_W), .K(K), .ADDR_W(ADDR_W), .SHIFT(SHIFT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int wModel  [CONV_NUM][K];
    int samples [400];
    int expOut  [CONV_NUM][DEPTH];
    int expN;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic writeWeight(input int c, input int t, input int v);
        @(negedge clk);
        bus.flt_we   = 1'b1;
        bus.flt_ch   = CH_W'(c);
        bus.flt_tap  = TAP_W'(t);
        bus.flt_data = DATA_W'(v);
        @(negedge clk);
        bus.flt_we   = 1'b0;
        wModel[c][t] = v;
    endtask

    // Output y[j] of channel c is the dot product of its taps with samples j*stride .. j*stride+K-1.
    function automatic void computeModel(input int len, input bit s2, input bit relu);
        int step;
        int sum;
        step = s2 ? 2 : 1;
        expN = 0;
        for (int m = K; m <= len; m++) begin
            if ((m - K) % step == 0) begin
                for (int c = 0; c < CONV_NUM; c++) begin
                    sum = 0;
                    for (int t = 0; t < K; t++) sum += wModel[c][t] * samples[m-K+t];
                    sum = sum >>> SHIFT;
                    if (relu && sum < 0) sum = 0;
                    if (sum > OUT_MAX) sum = OUT_MAX;
                    else if (sum < OUT_MIN) sum = OUT_MIN;
                    if (expN < DEPTH) expOut[c][expN] = sum;
                end
                expN++;
            end
        end
    endfunction

    task automatic applyStimulus(input string name, input int len, input bit s2,
                                 input bit relu, input int pct);
        int idx, expectLow, seqErrs, doneCnt, cycles, budget, expCount;
        bit prevAcc, finished, expReady, expDone;
        computeModel(len, s2, relu);
        expCount = (expN < DEPTH) ? expN : DEPTH;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len     = 16'(len);
        bus.stride2 = s2;
        bus.relu_en = relu;
        @(negedge clk);
        bus.start = 1'b0;
        if (len > 0) begin
            bus.start    = 1'b1;
            bus.flt_we   = 1'b1;
            bus.flt_ch   = '0;
            bus.flt_tap  = '0;
            bus.flt_data = DATA_W'($urandom);
        end
        idx = 0; expectLow = 0; seqErrs = 0; doneCnt = 0; cycles = 0;
        prevAcc = 1'b0; finished = 1'b0;
        budget = (len + 2) * (K + 2) * 8 + 100;
        while (!finished && cycles < budget) begin
            if (cycles == 1) begin
                bus.start  = 1'b0;
                bus.flt_we = 1'b0;
            end
            if (prevAcc) begin
                idx++;
                if (idx >= K && ((idx - K) % (s2 ? 2 : 1)) == 0) expectLow = K + 1;
            end
            expReady = (idx < len) && (expectLow == 0);
            expDone  = (idx == len) && (expectLow == 0);
            if (bus.in_ready !== expReady || bus.done !== expDone || bus.busy !== 1'b1) seqErrs++;
            if (bus.done === 1'b1) doneCnt++;
            if (expDone) finished = 1'b1;
            if (expectLow > 0) expectLow--;
            if (!finished && idx < len) begin
                bus.in_valid = ($urandom_range(0, 99) < pct);
                bus.in_data  = DATA_W'(samples[idx]);
            end else begin
                bus.in_valid = 1'b0;
            end
            prevAcc = bus.in_valid && (bus.in_ready === 1'b1);
            cycles++;
            if (!finished) @(negedge clk);
        end
        bus.start = 1'b0; bus.flt_we = 1'b0; bus.in_valid = 1'b0;
        checkOutput({name, "_finished"}, int'(finished), 1);
        checkOutput({name, "_handshake_errs"}, seqErrs, 0);
        @(negedge clk);
        if (bus.done === 1'b1) doneCnt++;
        checkOutput({name, "_done_pulses"}, doneCnt, 1);
        checkOutput({name, "_busy_after"}, int'(bus.busy), 0);
        checkOutput({name, "_ofm_count"}, int'(bus.ofm_count), expCount);
        for (int i = 0; i < expCount; i++) begin
            for (int c = 0; c < CONV_NUM; c++) bus.ofm_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(i);
            @(negedge clk);
            for (int c = 0; c < CONV_NUM; c++) begin
                checkOutput($sformatf("%s_ch%0d_y%0d", name, c, i),
                            int'($signed(bus.ofm_out[c*DATA_W +: DATA_W])), expOut[c][i]);
            end
        end
    endtask

    task automatic randomWeights();
        for (int c = 0; c < CONV_NUM; c++)
            for (int t = 0; t < K; t++) writeWeight(c, t, int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic randomSamples(input int n);
        for (int i = 0; i < n; i++) samples[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        int len;
        bit inMac, doneSeen;
        vectors = 0; miscompares = 0;
        bus.start = 0; bus.len = 0; bus.stride2 = 0; bus.relu_en = 0;
        bus.flt_we = 0; bus.flt_ch = 0; bus.flt_tap = 0; bus.flt_data = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.ofm_addr = 0;
        for (int c = 0; c < CONV_NUM; c++) for (int t = 0; t < K; t++) wModel[c][t] = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", int'(bus.in_ready), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_done", int'(bus.done), 0);
        checkOutput("rst_ofm_count", int'(bus.ofm_count), 0);
        checkOutput("rst_ofm_out", int'(bus.ofm_out), 0);
        rst = 1'b0;
        $display("[TB] reset released");

        randomWeights();
        for (int t = 0; t < K; t++) writeWeight(0, t, 1);
        for (int i = 0; i < 8; i++) samples[i] = i + 1;
        applyStimulus("ones_s1", 8, 1'b0, 1'b0, 100);
        applyStimulus("ones_s2", 8, 1'b1, 1'b0, 100);

        for (int t = 0; t < K; t++) writeWeight(1, t, -1);
        applyStimulus("neg_norelu", 4, 1'b0, 1'b0, 100);
        applyStimulus("neg_relu", 4, 1'b0, 1'b1, 100);

        for (int c = 0; c < CONV_NUM; c++) for (int t = 0; t < K; t++) writeWeight(c, t, 127);
        for (int i = 0; i < 4; i++) samples[i] = 127;
        applyStimulus("saturate", 4, 1'b0, 1'b0, 100);

        randomSamples(8);
        applyStimulus("len3", 3, 1'b0, 1'b0, 70);
        applyStimulus("len0", 0, 1'b0, 1'b0, 100);

        for (int r = 0; r < 6; r++) begin
            randomWeights();
            len = int'($urandom_range(0, 40));
            randomSamples(len);
            applyStimulus($sformatf("rand%0d", r), len, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), int'($urandom_range(30, 100)));
        end

        randomWeights();
        randomSamples(300);
        applyStimulus("long", 300, 1'b0, 1'b0, 80);

        $display("[TB] reset during MAC");
        @(negedge clk);
        bus.start = 1'b1; bus.len = 16'd8; bus.stride2 = 1'b0; bus.relu_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        inMac = 1'b0;
        for (int cyc = 0; cyc < 30 && !inMac; cyc++) begin
            bus.in_data = DATA_W'(cyc + 1);
            @(negedge clk);
            if (bus.in_ready === 1'b0) inMac = 1'b1;
        end
        bus.in_valid = 1'b0;
        checkOutput("midrun_reached_mac", int'(inMac), 1);
        checkOutput("midrun_busy_before", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrun_rst_busy", int'(bus.busy), 0);
        checkOutput("midrun_rst_in_ready", int'(bus.in_ready), 0);
        checkOutput("midrun_rst_done", int'(bus.done), 0);
        checkOutput("midrun_rst_ofm_count", int'(bus.ofm_count), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < CONV_NUM; c++) for (int t = 0; t < K; t++) wModel[c][t] = 0;
        doneSeen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneSeen = 1'b1;
        end
        checkOutput("midrun_no_done", int'(doneSeen), 0);

        randomSamples(6);
        applyStimulus("post_rst_zero_w", 6, 1'b0, 1'b0, 100);
        randomWeights();
        for (int t = 0; t < K; t++) writeWeight(0, t, 1);
        for (int i = 0; i < 8; i++) samples[i] = i + 1;
        applyStimulus("post_rst_ones", 8, 1'b0, 1'b0, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
